// File: rtl/rv_dtcm_arbiter_pkg.sv
// Shared types and constants for the DTCM arbiter slice.
// Contents: default widths/depth, clog2 helper, response-owner enum and
// response register struct.
package rv_dtcm_arbiter_pkg;

    localparam int MXLEN     = 32;    // core data width
    localparam int DTCM_SIZE = 1024;  // DTCM depth in words

    // Ceiling log2, never below 1 so a port range is always legal.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    typedef enum logic {
        OWNER_M0 = 1'b0,
        OWNER_M1 = 1'b1
    } owner_e;

    // One-stage response pipeline contents.
    typedef struct packed {
        logic   vld;
        owner_e owner;
        logic   is_rd;
        logic   err;
    } rsp_t;

endpackage

// File: rtl/rv_dtcm_arbiter_if.sv
// Requester-side bus of the DTCM arbiter (one instance per master).
// master modport: the requester (LSU or debug/DMA).
// slave modport : the arbiter.
//   req/addr/we/strb/wdata : request, held stable until gnt
//   gnt                    : transfer accepted when req & gnt
//   rvalid/rdata/err       : response, one cycle after acceptance
interface rv_dtcm_arbiter_if #(
    parameter int DW = 32
);
    logic            req;
    logic            gnt;
    logic [DW-1:0]   addr;
    logic            we;
    logic [DW/8-1:0] strb;
    logic [DW-1:0]   wdata;
    logic            rvalid;
    logic [DW-1:0]   rdata;
    logic            err;

    modport master (
        output req, addr, we, strb, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, strb, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/rv_prio_arb2.sv
// Two-way fixed-priority arbiter with priority swap.
//   req0/req1 : requests
//   swap      : 0 -> req0 wins ties, 1 -> req1 wins ties
//   gnt0/gnt1 : one-hot-or-zero grants, only ever with the matching req
module rv_prio_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic swap,
    output logic gnt0,
    output logic gnt1
);
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (swap) begin
            gnt1 = req1;
            gnt0 = req0 & ~req1;
        end else begin
            gnt0 = req0;
            gnt1 = req1 & ~req0;
        end
    end
endmodule

// File: rtl/rv_dtcm_arbiter.sv
// Shares the single DTCM port between the LSU (m0) and a debug/DMA master (m1).
//   clk, rst_n        : clock, synchronous active-low reset
//   m0, m1            : requester buses (slave side)
//   dtcm_addr_o       : word address to the DTCM
//   dtcm_wr_en_o      : write enable, dtcm_wr_strobe_o / dtcm_wr_data_o with it
//   dtcm_rd_en_o      : read enable; dtcm_rd_data_i is valid the next cycle
// Grant and DTCM drive are combinational; the response is routed through a
// single register stage, so a new request can be accepted every cycle.
module rv_dtcm_arbiter
    import rv_dtcm_arbiter_pkg::*;
#(
    parameter int DW         = MXLEN,
    parameter int DEPTH      = DTCM_SIZE,
    parameter int STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    rv_dtcm_arbiter_if.slave         m0,
    rv_dtcm_arbiter_if.slave         m1,
    output logic [clog2(DEPTH)-1:0]  dtcm_addr_o,
    output logic                     dtcm_wr_en_o,
    output logic [DW/8-1:0]          dtcm_wr_strobe_o,
    output logic [DW-1:0]            dtcm_wr_data_o,
    output logic                     dtcm_rd_en_o,
    input  logic [DW-1:0]            dtcm_rd_data_i
);
    localparam int AW  = clog2(DEPTH);
    localparam int SCW = clog2(STARVE_MAX + 1);

    logic           gnt0, gnt1, any_gnt, swap, in_range, sel_we, rsp_live;
    logic [DW-1:0]  sel_addr;
    logic [SCW-1:0] starve_cnt;
    rsp_t           rsp_q;

    // m1 takes priority once it has been refused STARVE_MAX cycles in a row.
    assign swap = (starve_cnt == SCW'(STARVE_MAX));

    rv_prio_arb2 u_arb (
        .req0 (m0.req & rst_n),
        .req1 (m1.req & rst_n),
        .swap (swap),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    assign m0.gnt  = gnt0;
    assign m1.gnt  = gnt1;
    assign any_gnt = gnt0 | gnt1;

    // Request mux; with no grant it follows m0 but the enables stay low.
    assign sel_addr         = gnt1 ? m1.addr  : m0.addr;
    assign sel_we           = gnt1 ? m1.we    : m0.we;
    assign dtcm_wr_strobe_o = gnt1 ? m1.strb  : m0.strb;
    assign dtcm_wr_data_o   = gnt1 ? m1.wdata : m0.wdata;
    assign dtcm_addr_o      = sel_addr[AW-1:0];

    // Full-width compare so high address bits cannot alias into the array.
    assign in_range     = (sel_addr < DW'(DEPTH));
    assign dtcm_wr_en_o = any_gnt &  sel_we & in_range;
    assign dtcm_rd_en_o = any_gnt & ~sel_we & in_range;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_q      <= '0;
            starve_cnt <= '0;
        end else begin
            rsp_q.vld   <= any_gnt;
            rsp_q.owner <= gnt1 ? OWNER_M1 : OWNER_M0;
            rsp_q.is_rd <= ~sel_we;
            rsp_q.err   <= any_gnt & ~in_range;
            if (m1.req && !gnt1) begin
                if (starve_cnt != SCW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    // A response pending when reset lands is suppressed in that same cycle.
    assign rsp_live = rsp_q.vld & rst_n;

    assign m0.rvalid = rsp_live & (rsp_q.owner == OWNER_M0);
    assign m1.rvalid = rsp_live & (rsp_q.owner == OWNER_M1);
    assign m0.err    = m0.rvalid & rsp_q.err;
    assign m1.err    = m1.rvalid & rsp_q.err;
    assign m0.rdata  = (m0.rvalid & rsp_q.is_rd & ~rsp_q.err) ? dtcm_rd_data_i : '0;
    assign m1.rdata  = (m1.rvalid & rsp_q.is_rd & ~rsp_q.err) ? dtcm_rd_data_i : '0;

endmodule

// File: tb/tb_rv_dtcm_arbiter.sv
module tb_rv_dtcm_arbiter;
    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int SMAX  = 4;
    localparam int AW    = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv_dtcm_arbiter_if #(.DW(DW)) m0_if ();
    rv_dtcm_arbiter_if #(.DW(DW)) m1_if ();

    logic [AW-1:0]   dtcm_addr;
    logic            dtcm_wr_en, dtcm_rd_en;
    logic [DW/8-1:0] dtcm_wr_strobe;
    logic [DW-1:0]   dtcm_wr_data, dtcm_rd_data;

    rv_dtcm_arbiter #(.DW(DW), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .m0               (m0_if),
        .m1               (m1_if),
        .dtcm_addr_o      (dtcm_addr),
        .dtcm_wr_en_o     (dtcm_wr_en),
        .dtcm_wr_strobe_o (dtcm_wr_strobe),
        .dtcm_wr_data_o   (dtcm_wr_data),
        .dtcm_rd_en_o     (dtcm_rd_en),
        .dtcm_rd_data_i   (dtcm_rd_data)
    );

    // DTCM behavioural model: byte-strobed write, 1-cycle read.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (dtcm_wr_en)
            for (int b = 0; b < DW/8; b++)
                if (dtcm_wr_strobe[b]) mem[dtcm_addr][8*b +: 8] <= dtcm_wr_data[8*b +: 8];
        if (dtcm_rd_en) dtcm_rd_data <= mem[dtcm_addr];
    end

    typedef struct {
        string name;
        logic r0; logic w0; logic [31:0] a0; logic [31:0] d0; logic [3:0] s0;
        logic r1; logic w1; logic [31:0] a1; logic [31:0] d1; logic [3:0] s1;
        logic eg0; logic eg1; logic ewr; logic erd;
    } vec_t;

    typedef struct {
        logic owner; logic err; logic [31:0] rdata;
    } exp_t;

    vec_t        vq[$];
    exp_t        sb[$];
    logic [31:0] ref_mem [DEPTH];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r0, w0, input logic [31:0] a0, d0, input logic [3:0] s0,
                         input logic r1, w1, input logic [31:0] a1, d1, input logic [3:0] s1);
        m0_if.req = r0; m0_if.we = w0; m0_if.addr = a0; m0_if.wdata = d0; m0_if.strb = s0;
        m1_if.req = r1; m1_if.we = w1; m1_if.addr = a1; m1_if.wdata = d1; m1_if.strb = s1;
    endtask

    task automatic push(input logic owner, we, input logic [31:0] a, d, input logic [3:0] s);
        exp_t e;
        e.owner = owner;
        e.err   = (a >= DEPTH);
        e.rdata = (!we && !e.err) ? ref_mem[a[AW-1:0]] : 32'h0;
        if (we && !e.err)
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[a[AW-1:0]][8*b +: 8] = d[8*b +: 8];
        sb.push_back(e);
    endtask

    // Response check: any expectation pushed last cycle must show up now.
    task automatic check_rsp();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.owner == 1'b0) begin
                chk("m0_rvalid", m0_if.rvalid, 1); chk("m1_rvalid_idle", m1_if.rvalid, 0);
                chk("m0_err", m0_if.err, e.err);   chk("m0_rdata", m0_if.rdata, e.rdata);
            end else begin
                chk("m1_rvalid", m1_if.rvalid, 1); chk("m0_rvalid_idle", m0_if.rvalid, 0);
                chk("m1_err", m1_if.err, e.err);   chk("m1_rdata", m1_if.rdata, e.rdata);
            end
        end else begin
            chk("m0_no_rvalid", m0_if.rvalid, 0);
            chk("m1_no_rvalid", m1_if.rvalid, 0);
        end
    endtask

    task automatic accept();
        if (m0_if.req && m0_if.gnt)
            push(1'b0, m0_if.we, m0_if.addr, m0_if.wdata, m0_if.strb);
        else if (m1_if.req && m1_if.gnt)
            push(1'b1, m1_if.we, m1_if.addr, m1_if.wdata, m1_if.strb);
    endtask

    function automatic vec_t mk(input string n,
        input logic r0, w0, input logic [31:0] a0, d0, input logic [3:0] s0,
        input logic r1, w1, input logic [31:0] a1, d1, input logic [3:0] s1,
        input logic eg0, eg1, ewr, erd);
        vec_t v;
        v.name = n; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.s0 = s0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.s1 = s1;
        v.eg0 = eg0; v.eg1 = eg1; v.ewr = ewr; v.erd = erd;
        return v;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with both masters requesting: nothing may leak out.
        drive(1, 1, 32'h0, 32'hA0, 4'hF, 1, 1, 32'h1, 32'hA1, 4'hF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_gnt0", m0_if.gnt, 0);       chk("rst_gnt1", m1_if.gnt, 0);
            chk("rst_rvalid0", m0_if.rvalid, 0); chk("rst_rvalid1", m1_if.rvalid, 0);
            chk("rst_wr_en", dtcm_wr_en, 0);     chk("rst_rd_en", dtcm_rd_en, 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_gnt0", m0_if.gnt, 1); chk("rel_gnt1", m1_if.gnt, 0);
        check_rsp(); accept();
        @(posedge clk); #1 m0_if.req = 1'b0;
        @(negedge clk);
        chk("rel_gnt1_next", m1_if.gnt, 1);
        check_rsp(); accept();
        @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        vq.push_back(mk("w10",     1,1,32'h10,32'hDEADBEEF,4'hF, 0,0,0,0,0,               1,0,1,0));
        vq.push_back(mk("m1r10",   0,0,0,0,0,                    1,0,32'h10,0,0,          0,1,0,1));
        vq.push_back(mk("w0",      1,1,32'h0,32'hA0,4'hF,        0,0,0,0,0,               1,0,1,0));
        vq.push_back(mk("w1",      1,1,32'h1,32'hA1,4'hF,        0,0,0,0,0,               1,0,1,0));
        vq.push_back(mk("w2",      1,1,32'h2,32'hA2,4'hF,        0,0,0,0,0,               1,0,1,0));
        vq.push_back(mk("w3",      1,1,32'h3,32'hA3,4'hF,        0,0,0,0,0,               1,0,1,0));
        vq.push_back(mk("r0",      1,0,32'h0,0,0,                0,0,0,0,0,               1,0,0,1));
        vq.push_back(mk("r1",      1,0,32'h1,0,0,                0,0,0,0,0,               1,0,0,1));
        vq.push_back(mk("r2",      1,0,32'h2,0,0,                0,0,0,0,0,               1,0,0,1));
        vq.push_back(mk("r3",      1,0,32'h3,0,0,                0,0,0,0,0,               1,0,0,1));
        vq.push_back(mk("m1oor",   0,0,0,0,0,                    1,0,DEPTH,0,0,           0,1,0,0));
        vq.push_back(mk("m1w20",   0,0,0,0,0,                    1,1,32'h20,32'hFFFFFFFF,4'hF, 0,1,1,0));
        vq.push_back(mk("m0w20p",  1,1,32'h20,32'h11223344,4'h5, 0,0,0,0,0,               1,0,1,0));
        vq.push_back(mk("m1r20",   0,0,0,0,0,                    1,0,32'h20,0,0,          0,1,0,1));
        vq.push_back(mk("both_w",  1,1,32'h30,32'h55,4'hF,       1,0,32'h30,0,0,          1,0,1,0));
        vq.push_back(mk("m1_held", 0,0,0,0,0,                    1,0,32'h30,0,0,          0,1,0,1));
        vq.push_back(mk("m0oor_hi",1,0,32'h70000000,0,0,         0,0,0,0,0,               1,0,0,0));
        vq.push_back(mk("m1w_top", 0,0,0,0,0,                    1,1,DEPTH-1,32'hCAFEF00D,4'hF, 0,1,1,0));
        vq.push_back(mk("m0r_top", 1,0,DEPTH-1,0,0,              0,0,0,0,0,               1,0,0,1));
        vq.push_back(mk("idle",    0,0,0,0,0,                    0,0,0,0,0,               0,0,0,0));

        foreach (vq[i]) begin
            drive(vq[i].r0, vq[i].w0, vq[i].a0, vq[i].d0, vq[i].s0,
                  vq[i].r1, vq[i].w1, vq[i].a1, vq[i].d1, vq[i].s1);
            @(negedge clk);
            check_rsp();
            chk({vq[i].name, "_gnt0"}, m0_if.gnt, vq[i].eg0);
            chk({vq[i].name, "_gnt1"}, m1_if.gnt, vq[i].eg1);
            chk({vq[i].name, "_wr_en"}, dtcm_wr_en, vq[i].ewr);
            chk({vq[i].name, "_rd_en"}, dtcm_rd_en, vq[i].erd);
            accept();
            @(posedge clk); #1;
        end

        // Both masters requesting every cycle: m1 wins every fifth cycle.
        drive(1, 0, 32'h10, 0, 0, 1, 0, 32'h0, 0, 0);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            check_rsp();
            chk($sformatf("starve_gnt0_c%0d", k), m0_if.gnt, (k % 5) != 0);
            chk($sformatf("starve_gnt1_c%0d", k), m1_if.gnt, (k % 5) == 0);
            accept();
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); check_rsp(); accept();
        @(posedge clk); #1;

        // Read accepted, then reset lands before its response: it must vanish.
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("pre_rst_gnt0", m0_if.gnt, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("drop_rvalid0", m0_if.rvalid, 0); chk("drop_rvalid1", m1_if.rvalid, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rvalid0", m0_if.rvalid, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 1, 0, 32'h10, 0, 0);
        @(negedge clk);
        check_rsp();
        chk("post_rst_gnt1", m1_if.gnt, 1); chk("post_rst_rd_en", dtcm_rd_en, 1);
        accept();
        @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); check_rsp();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
